// File: rtl/clk_div_multi_if.sv
// +----------------------------------------------------------------------+
// | clk_div_multi_if : control/output bundle of the multi-channel divider |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface clk_div_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]       en_i;
  logic [N_CH*CNT_W-1:0] div_i;
  logic                  sync_i;
  logic [N_CH-1:0]       dclk_o;
  logic [N_CH-1:0]       tick_o;
  logic [N_CH-1:0]       run_o;

  modport master (
    output en_i,
    output div_i,
    output sync_i,
    input  dclk_o,
    input  tick_o,
    input  run_o
  );

  modport slave (
    input  en_i,
    input  div_i,
    input  sync_i,
    output dclk_o,
    output tick_o,
    output run_o
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_multi.sv
// +----------------------------------------------------------------------+
// | clk_div_multi : N_CH runtime-programmable 50% duty clock dividers     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module clk_div_multi #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  clk_div_multi_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic             dclk;
    logic             tick;
    logic             run;
    logic             en;
    logic             sync_hit;
    logic [CNT_W-1:0] div_in;

    assign en       = bus.en_i[c];
    assign div_in   = bus.div_i[c*CNT_W +: CNT_W];
    // Disabled channels ignore sync so the stop rules always win.
    assign sync_hit = bus.sync_i & en;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state <= IDLE;
        cnt   <= '0;
        div_q <= '0;
        dclk  <= 1'b0;
        tick  <= 1'b0;
        run   <= 1'b0;
      end else begin
        tick <= 1'b0;
        case (state)
          IDLE: begin
            if (en) begin
              div_q <= div_in;
              cnt   <= '0;
              state <= HI;
              dclk  <= 1'b1;
              tick  <= 1'b1;
              run   <= 1'b1;
            end
          end
          HI: begin
            if (sync_hit) begin
              div_q <= div_in;
              cnt   <= '0;
              tick  <= 1'b1;
            end else if (cnt != div_q) begin
              cnt <= cnt + 1'b1;
            end else begin
              // High phase always runs to completion, even when stopping.
              cnt  <= '0;
              dclk <= 1'b0;
              if (en) begin
                state <= LO;
              end else begin
                state <= IDLE;
                run   <= 1'b0;
              end
            end
          end
          LO: begin
            if (!en) begin
              cnt   <= '0;
              state <= IDLE;
              run   <= 1'b0;
            end else if (sync_hit || cnt == div_q) begin
              div_q <= div_in;
              cnt   <= '0;
              state <= HI;
              dclk  <= 1'b1;
              tick  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            dclk  <= 1'b0;
            run   <= 1'b0;
          end
        endcase
      end
    end

    assign bus.dclk_o[c] = dclk;
    assign bus.tick_o[c] = tick;
    assign bus.run_o[c]  = run;
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// +----------------------------------------------------------------------+
// | tb_clk_div_multi : directed scoreboard bench for clk_div_multi        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_clk_div_multi;
  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tick_err;
  int   exp_q[$];

  always #5 clk = ~clk;

  clk_div_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  clk_div_multi #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int v);
    exp_q.push_back(v);
  endtask

  task automatic compare(input string tag, input int obs);
    int e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  task automatic set_div(input int ch, input int val);
    bus.div_i[ch*CNT_W +: CNT_W] = val[CNT_W-1:0];
  endtask

  // Cycles until the next 0->1 of dclk_o[ch]; -1 on timeout. Counts tick/rise disagreements.
  task automatic wait_rise(input int ch, input int budget, output int cyc);
    logic prev;
    logic rise;
    prev = bus.dclk_o[ch];
    cyc  = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      rise = bus.dclk_o[ch] & ~prev;
      if (bus.tick_o[ch] !== rise) tick_err++;
      prev = bus.dclk_o[ch];
      if (rise) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_fall(input int ch, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (!bus.dclk_o[ch]) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.en_i   = '0;
    bus.sync_i = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int c;
    int n_hi;
    int n_tk;
    int f0;
    int f1;
    int exp_ns[N_CH];

    rst        = 1'b1;
    bus.en_i   = '0;
    bus.div_i  = '0;
    bus.sync_i = 1'b0;
    step();
    step();
    expect_val(0); compare("reset_dclk", int'(bus.dclk_o));
    expect_val(0); compare("reset_tick", int'(bus.tick_o));
    expect_val(0); compare("reset_run",  int'(bus.run_o));
    rst = 1'b0;

    // Four channels at 127/63/31/0, started together
    set_div(0, 127); set_div(1, 63); set_div(2, 31); set_div(3, 0);
    exp_ns[0] = 2560; exp_ns[1] = 1280; exp_ns[2] = 640; exp_ns[3] = 20;
    bus.en_i = 4'hF;
    step();
    expect_val(15); compare("start_dclk", int'(bus.dclk_o));
    expect_val(15); compare("start_tick", int'(bus.tick_o));
    expect_val(15); compare("start_run",  int'(bus.run_o));
    for (int ch = 0; ch < N_CH; ch++) begin
      tick_err = 0;
      wait_rise(ch, 600, c);
      wait_rise(ch, 600, c);
      expect_val(exp_ns[ch]); compare($sformatf("spacing_ns_ch%0d", ch), c * 10);
      expect_val(0);          compare($sformatf("tick_align_ch%0d", ch), tick_err);
    end

    // Largest divisor
    do_reset();
    set_div(0, 255);
    bus.en_i = 4'b0001;
    step();
    wait_rise(0, 600, c);
    expect_val(5120); compare("spacing_ns_div255", c * 10);

    // Divisor change mid-HI takes effect on next period only
    do_reset();
    set_div(0, 3);
    bus.en_i = 4'b0001;
    step();
    step();
    set_div(0, 9);
    wait_rise(0, 50, c);
    expect_val(8);  compare("div_chg_cur_period", (c < 0) ? c : c + 1);
    wait_rise(0, 50, c);
    expect_val(20); compare("div_chg_next_period", c);
    wait_fall(0, 50, c);
    expect_val(10); compare("div_chg_high_len", c);

    // Stop during HI: full high phase, then idle
    do_reset();
    set_div(0, 4);
    bus.en_i = 4'b0001;
    step();
    step();
    bus.en_i = 4'b0000;
    wait_fall(0, 20, c);
    expect_val(5); compare("stop_hi_high_len", (c < 0) ? c : c + 1);
    expect_val(0); compare("stop_hi_run", int'(bus.run_o[0]));
    n_hi = 0;
    n_tk = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_hi += int'(bus.dclk_o[0]);
      n_tk += int'(bus.tick_o[0]);
    end
    expect_val(0); compare("stop_hi_no_ticks", n_tk);
    expect_val(0); compare("stop_hi_stays_low", n_hi);

    // Stop during LO
    do_reset();
    set_div(0, 4);
    bus.en_i = 4'b0001;
    step();
    repeat (5) step();
    expect_val(0); compare("stop_lo_in_low", int'(bus.dclk_o[0]));
    expect_val(1); compare("stop_lo_run_before", int'(bus.run_o[0]));
    bus.en_i = 4'b0000;
    step();
    expect_val(0); compare("stop_lo_run", int'(bus.run_o[0]));
    expect_val(0); compare("stop_lo_dclk", int'(bus.dclk_o[0]));

    // Sync pulse aligns running channels, ignores disabled one
    do_reset();
    set_div(0, 4); set_div(1, 6); set_div(2, 2);
    bus.en_i = 4'b0001;
    step();
    repeat (3) step();
    bus.en_i = 4'b0011;
    repeat (4) step();
    bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
    expect_val(3); compare("sync_dclk", int'(bus.dclk_o & 4'b0111));
    expect_val(3); compare("sync_tick", int'(bus.tick_o & 4'b0111));
    expect_val(0); compare("sync_idle_run_ch2", int'(bus.run_o[2]));
    f0 = -1;
    f1 = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (f0 < 0 && !bus.dclk_o[0]) f0 = i;
      if (f1 < 0 && !bus.dclk_o[1]) f1 = i;
    end
    expect_val(5); compare("sync_fall_ch0", f0);
    expect_val(7); compare("sync_fall_ch1", f1);

    // Reset mid-HI, then restart with enables held
    do_reset();
    for (int ch = 0; ch < N_CH; ch++) set_div(ch, 4);
    bus.en_i = 4'hF;
    step();
    step();
    rst = 1'b1;
    step();
    expect_val(0); compare("midrst_dclk", int'(bus.dclk_o));
    expect_val(0); compare("midrst_tick", int'(bus.tick_o));
    expect_val(0); compare("midrst_run",  int'(bus.run_o));
    rst = 1'b0;
    step();
    expect_val(15); compare("restart_dclk", int'(bus.dclk_o));
    expect_val(15); compare("restart_tick", int'(bus.tick_o));
    expect_val(15); compare("restart_run",  int'(bus.run_o));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
